mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single-port 16-bit x 1024 synchronous block memory between the
// instruction-fetch unit and the load/store unit of the processor. Accepts one
// request per requester per cycle, selects one access per cycle by round-robin,
// and drives the memory port. Returns read data with fixed one-cycle latency.
// Sits between the control unit / datapath and the memory instance.
// PARAMETERS
// AW  10  memory address width (words)
// DW  16  memory data width
// PORTS
// clk        in   1   system clock; all logic on posedge
// rst_n      in   1   asynchronous active-low reset
// i_req      in   1   fetch request; held until i_gnt seen
// i_adrs     in   AW  fetch address; stable while i_req high
// i_gnt      out  1   fetch access issued this cycle
// i_rvalid   out  1   i_rdata valid (cycle after i_gnt)
// i_rdata    out  DW  fetch read data
// d_req      in   1   data request; held until d_gnt seen
// d_we       in   1   1 = store, 0 = load; stable while d_req high
// d_adrs     in   AW  data address
// d_wdata    in   DW  store data
// d_gnt      out  1   data access issued this cycle
// d_rvalid   out  1   d_rdata valid (cycle after a load's d_gnt; never for stores)
// d_rdata    out  DW  load read data
// mem_we     out  1   memory write enable
// mem_adrs   out  AW  memory address
// mem_din    out  DW  memory write data
// mem_dout   in   DW  memory read data; valid one cycle after address issued
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, last-winner=FETCH (data wins first
//   conflict), all mask bits 0, all gnt/rvalid/mem_we 0, mem_adrs/mem_din 0.
// - FSM states: IDLE, GNT_I, GNT_D. State is registered; one state = one cycle.
// - Eligibility: i_elig = i_req & ~i_mask; d_elig = d_req & ~d_mask.
//   A requester granted in cycle N is masked in cycle N+1 (prevents regrant on a
//   stale req before the requester drops it). Mask clears automatically after 1 cycle.
// - Next state: both eligible -> grant the one NOT last-winner; one eligible ->
//   grant it; none -> IDLE. Last-winner updates only on a grant.
// - In GNT_I: i_gnt=1, mem_adrs=i_adrs, mem_we=0. In GNT_D: d_gnt=1,
//   mem_adrs=d_adrs, mem_din=d_wdata, mem_we=d_we. In IDLE: mem_we=0, gnt=0.
//   gnt and mem_* are registered outputs (no comb path req->gnt).
// - Read return: i_rvalid=1 in cycle after GNT_I; d_rvalid=1 in cycle after a
//   GNT_D with d_we=0. rdata = mem_dout in that cycle, passed through (both
//   rdata ports always show mem_dout; only rvalid qualifies).
// - Throughput: one access per cycle; with both requesting continuously grants
//   alternate I,D,I,D. Single requester alone gets every other cycle.
// - Simultaneous events: rvalid for access N and gnt for access N+1 coincide;
//   independent. Store followed by load to same address: load returns new data.
// - Requester dropping req before gnt: request silently withdrawn, no access.
// - Reset mid-operation: pending rvalid dropped; in-flight write may or may not
//   have completed in memory (memory is not reset).
// - Requester must not change adrs/we/wdata while req high and gnt not yet seen.
// TESTING
// 1 Reset: rst_n=0 mid-burst -> all gnt/rvalid/mem_we 0 immediately, state IDLE.
// 2 Fetch only: i_req, i_adrs=0x005 (mem[5]=0xBEEF) -> i_gnt next cycle,
//   i_rvalid+i_rdata=0xBEEF cycle after; d_gnt never asserted.
// 3 Store/load: d_we=1 adrs=0x3FF wdata=0x1234, then load 0x3FF -> mem_we one
//   cycle, d_rvalid with 0x1234; no d_rvalid for store.
// 4 Conflict after reset: i_req and d_req same cycle held -> grants D,I,D,I;
//   exactly one gnt per cycle, never both.
// 5 Withdrawal: d_req pulsed 1 cycle while fetch granted -> no d_gnt, no mem_we.
// 6 Back-to-back: continuous fetch 0x000..0x00F with data loads interleaved ->
//   every rdata matches model, rvalid exactly 1 cycle after its gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one block-memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_adrs,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adrs,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // The state names the access being presented to the memory this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  // 0 = fetch won last, 1 = data won last; reset to fetch so data wins first.
  logic lastWinnerD;
  // A requester is ignored for one cycle after its grant, while its req is stale.
  logic iMask;
  logic dMask;
  logic iElig;
  logic dElig;

  logic          memWeQ;
  logic [AW-1:0] memAdrsQ;
  logic [DW-1:0] memDinQ;
  logic          iRvalidQ;
  logic          dRvalidQ;

  // Eligibility and round-robin choice of the access for the next cycle
  always_comb begin
    iElig     = i_req & ~iMask;
    dElig     = d_req & ~dMask;
    nextState = IDLE;
    if (iElig && dElig) begin
      nextState = lastWinnerD ? GNT_I : GNT_D;
    end else if (iElig) begin
      nextState = GNT_I;
    end else if (dElig) begin
      nextState = GNT_D;
    end
  end

  // State register, one-cycle grant masks and last-winner tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      iMask       <= 1'b0;
      dMask       <= 1'b0;
      lastWinnerD <= 1'b0;
    end else begin
      state <= nextState;
      iMask <= (nextState == GNT_I);
      dMask <= (nextState == GNT_D);
      if (nextState == GNT_I) begin
        lastWinnerD <= 1'b0;
      end else if (nextState == GNT_D) begin
        lastWinnerD <= 1'b1;
      end
    end
  end

  // Registered memory port; address/data hold their last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memWeQ   <= 1'b0;
      memAdrsQ <= '0;
      memDinQ  <= '0;
    end else begin
      case (nextState)
        GNT_I: begin
          memWeQ   <= 1'b0;
          memAdrsQ <= i_adrs;
        end
        GNT_D: begin
          memWeQ   <= d_we;
          memAdrsQ <= d_adrs;
          memDinQ  <= d_wdata;
        end
        default: begin
          memWeQ <= 1'b0;
        end
      endcase
    end
  end

  // Read-return qualifiers: one cycle after a read access, never for stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
    end else begin
      iRvalidQ <= (state == GNT_I);
      dRvalidQ <= (state == GNT_D) && !memWeQ;
    end
  end

  assign i_gnt    = (state == GNT_I);
  assign d_gnt    = (state == GNT_D);
  assign mem_we   = memWeQ;
  assign mem_adrs = memAdrsQ;
  assign mem_din  = memDinQ;
  assign i_rvalid = iRvalidQ;
  assign d_rvalid = dRvalidQ;
  // Both read ports see the memory output directly; rvalid says whose it is.
  assign i_rdata  = mem_dout;
  assign d_rdata  = mem_dout;

endmodule
